// File: rtl/pcs_rx_pkg.sv
// Shared 64b/66b PCS constants, unpacker state encoding and sync-header helper.
// Imported by both the TX and RX block paths.
package pcs_rx_pkg;

    localparam int BSIZE = 66;
    localparam int NBLK  = 4;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } unpack_state_e;

    function automatic logic sh_valid(input logic [1:0] hdr);
        return (hdr == SH_DATA) || (hdr == SH_CTRL);
    endfunction

endpackage

// File: rtl/rx_sh_err_cnt.sv
// Sync-header legality check on the presented block plus a saturating count
// of accepted blocks whose header was illegal.
module rx_sh_err_cnt
    import pcs_rx_pkg::*;
#(
    parameter int ERR_W = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [1:0]       hdr,
    input  logic             vld,
    input  logic             fire,
    output logic             hdr_err,
    output logic [ERR_W-1:0] err_cnt
);

    logic [ERR_W-1:0] cnt_q, cnt_d;

    assign hdr_err = vld & ~sh_valid(hdr);
    assign err_cnt = cnt_q;

    // Holds at all-ones instead of wrapping back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (fire && hdr_err && (cnt_q != {ERR_W{1'b1}})) begin
            cnt_d = cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_block_unpacker.sv
// Pops wide words from the RX CDC FIFO (first-word-fall-through) and replays
// them as one 66-bit block per cycle, block 0 first, over valid/ready.
module rx_block_unpacker #(
    parameter int DSIZE = 264,
    parameter int BSIZE = pcs_rx_pkg::BSIZE,
    parameter int NBLK  = pcs_rx_pkg::NBLK,
    parameter int ERR_W = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    input  logic             flush,
    output logic [BSIZE-1:0] blk_data,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic             hdr_err,
    output logic [ERR_W-1:0] err_cnt
);

    import pcs_rx_pkg::unpack_state_e;
    import pcs_rx_pkg::ST_EMPTY;
    import pcs_rx_pkg::ST_HOLD;

    localparam int IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;

    if (DSIZE != NBLK * BSIZE) begin : g_size_check
        $error("rx_block_unpacker: DSIZE must equal NBLK*BSIZE");
    end

    unpack_state_e    state_q, state_d;
    logic [DSIZE-1:0] hold_q, hold_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             fire;
    logic             last;

    assign blk_valid = (state_q == ST_HOLD);
    assign blk_data  = hold_q[idx_q*BSIZE +: BSIZE];
    assign fire      = blk_valid & blk_ready;
    assign last      = (idx_q == IDX_W'(NBLK - 1));

    // Refill either into an empty holder or on the very cycle the last block leaves.
    assign rinc = ~rrst & ~flush & ~rempty & (~blk_valid | (fire & last));

    // flush beats load, and load beats the plain end-of-word drain.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        if (flush) begin
            state_d = ST_EMPTY;
            idx_d   = '0;
        end else if (rinc) begin
            state_d = ST_HOLD;
            hold_d  = rdata;
            idx_d   = '0;
        end else if (fire) begin
            if (last) begin
                state_d = ST_EMPTY;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // The word itself needs no reset; it is only observed while in ST_HOLD.
    always_ff @(posedge rclk) begin
        hold_q <= hold_d;
    end

    rx_sh_err_cnt #(
        .ERR_W (ERR_W)
    ) u_sh_err_cnt (
        .rclk    (rclk),
        .rrst    (rrst),
        .hdr     (blk_data[BSIZE-1 -: 2]),
        .vld     (blk_valid),
        .fire    (fire & ~flush),
        .hdr_err (hdr_err),
        .err_cnt (err_cnt)
    );

endmodule
